// File: rtl/serial_arbiter_if.sv
// Bus bundle between the requesters and the serial arbiter: parallel request side
// plus the serial output stream.
interface serial_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  dout;
    logic                  dout_valid;
    logic                  frame_start;
    logic [IW-1:0]         src_id;
    logic                  busy;

    modport master (
        output req_valid,
        output req_data,
        input  req_ready,
        input  dout,
        input  dout_valid,
        input  frame_start,
        input  src_id,
        input  busy
    );

    modport slave (
        input  req_valid,
        input  req_data,
        output req_ready,
        output dout,
        output dout_valid,
        output frame_start,
        output src_id,
        output busy
    );
endinterface

// File: rtl/serial_arbiter.sv
// Round-robin arbiter that accepts one parallel word at a time from NREQ requesters
// and serialises it MSB first, back-to-back when another request is pending.
module serial_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    serial_arbiter_if.slave  bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [CW-1:0]       cnt_r;
    logic [CW-1:0]       cnt_nxt_s;
    logic [WIDTH-1:0]    shift_r;
    logic [WIDTH-1:0]    shift_nxt_s;
    logic [IW-1:0]       last_grant_r;
    logic [IW-1:0]       last_grant_nxt_s;
    logic [IW-1:0]       src_id_r;
    logic [IW-1:0]       src_id_nxt_s;
    logic                dout_valid_r;
    logic                dout_valid_nxt_s;
    logic                frame_start_r;
    logic                frame_start_nxt_s;
    logic                busy_r;
    logic                busy_nxt_s;

    logic                window_s;
    logic [IW:0]         pick_s;
    logic                found_s;
    logic [IW-1:0]       grant_s;
    logic [NREQ-1:0]     ready_s;
    logic                accept_s;
    logic [WIDTH-1:0]    word_s;

    // Searching downward from the farthest candidate lets the nearest valid one win.
    function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] v, input logic [IW-1:0] last);
        logic [IW:0] res;
        int          idx;
        res = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(last) + k) % NREQ;
            if (v[idx]) begin
                res = {1'b1, IW'(idx)};
            end
        end
        return res;
    endfunction

    assign window_s = (state_r == IDLE) || ((state_r == SHIFT) && (cnt_r == CNT_LAST));
    assign pick_s   = rr_pick(bus.req_valid, last_grant_r);
    assign found_s  = pick_s[IW];
    assign grant_s  = pick_s[IW-1:0];
    assign word_s   = bus.req_data[int'(grant_s)*WIDTH +: WIDTH];

    // One-hot acceptance strobe, only inside an accept window and never during reset.
    always_comb begin
        ready_s = '0;
        if (!rst && window_s && found_s) begin
            ready_s = {{(NREQ-1){1'b0}}, 1'b1} << grant_s;
        end else begin
            ready_s = '0;
        end
    end

    assign accept_s = |(bus.req_valid & ready_s);

    // Next-state and next-output computation for the IDLE/SHIFT machine.
    always_comb begin
        state_nxt_s       = state_r;
        cnt_nxt_s         = cnt_r;
        shift_nxt_s       = shift_r;
        last_grant_nxt_s  = last_grant_r;
        src_id_nxt_s      = src_id_r;
        dout_valid_nxt_s  = 1'b0;
        frame_start_nxt_s = 1'b0;
        busy_nxt_s        = 1'b0;
        if (accept_s) begin
            state_nxt_s       = SHIFT;
            cnt_nxt_s         = '0;
            shift_nxt_s       = word_s;
            last_grant_nxt_s  = grant_s;
            src_id_nxt_s      = grant_s;
            dout_valid_nxt_s  = 1'b1;
            frame_start_nxt_s = 1'b1;
            busy_nxt_s        = 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    state_nxt_s = IDLE;
                    shift_nxt_s = '0;
                end
                SHIFT: begin
                    if (cnt_r == CNT_LAST) begin
                        state_nxt_s = IDLE;
                        cnt_nxt_s   = '0;
                        shift_nxt_s = '0;
                    end else begin
                        cnt_nxt_s        = cnt_r + {{(CW-1){1'b0}}, 1'b1};
                        shift_nxt_s      = {shift_r[WIDTH-2:0], 1'b0};
                        dout_valid_nxt_s = 1'b1;
                        busy_nxt_s       = 1'b1;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = '0;
                    shift_nxt_s = '0;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            cnt_r         <= '0;
            shift_r       <= '0;
            last_grant_r  <= IW'(NREQ - 1);
            src_id_r      <= '0;
            dout_valid_r  <= 1'b0;
            frame_start_r <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            cnt_r         <= cnt_nxt_s;
            shift_r       <= shift_nxt_s;
            last_grant_r  <= last_grant_nxt_s;
            src_id_r      <= src_id_nxt_s;
            dout_valid_r  <= dout_valid_nxt_s;
            frame_start_r <= frame_start_nxt_s;
            busy_r        <= busy_nxt_s;
        end
    end

    // The shift register is cleared when idle, so its MSB is the serial output directly.
    assign bus.req_ready   = ready_s;
    assign bus.dout        = shift_r[WIDTH-1];
    assign bus.dout_valid  = dout_valid_r;
    assign bus.frame_start = frame_start_r;
    assign bus.src_id      = src_id_r;
    assign bus.busy        = busy_r;
endmodule

// File: tb/tb_serial_arbiter.sv
// Directed table-driven bench for serial_arbiter (NREQ=4, WIDTH=4) plus a saturation
// rotation run and a bounded drain check.
module tb_serial_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    serial_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        rs;
        logic [3:0]  v;
        logic [15:0] d;
        logic [3:0]  rdy;
        logic        dout;
        logic        dv;
        logic        fs;
        logic [1:0]  src;
        logic        busy;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic add_row(input logic rs, input logic [3:0] v, input logic [15:0] d,
                           input logic [3:0] rdy, input logic dout, input logic dv,
                           input logic fs, input logic [1:0] src, input logic busy);
        vec_t e;
        e.rs = rs; e.v = v; e.d = d; e.rdy = rdy; e.dout = dout;
        e.dv = dv; e.fs = fs; e.src = src; e.busy = busy;
        tbl.push_back(e);
    endtask

    // Four rows of one serialised word w (MSB first); rdy_last is the grant in its last bit.
    task automatic add_word(input logic [3:0] w, input logic [1:0] src, input logic [3:0] v,
                            input logic [15:0] d, input logic [3:0] rdy_last);
        for (int b = 3; b >= 0; b--) begin
            add_row(1'b0, v, d, (b == 0) ? rdy_last : 4'b0000, w[b], 1'b1, (b == 3), src, 1'b1);
        end
    endtask

    task automatic chk(input string name, input int row, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (step %0d): got %0h, expected %0h", name, row, act, exp);
        end
    endtask

    initial begin
        int k;
        rst            = 1'b1;
        bus.req_valid  = 4'b1111;
        bus.req_data   = 16'h0000;

        // Reset held with every requester valid.
        add_row(1'b1, 4'b1111, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        add_row(1'b1, 4'b1111, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        // Single word 1011 from requester 0; data changes after acceptance are ignored.
        add_row(1'b0, 4'b0001, 16'h000B, 4'b0001, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        add_word(4'hB, 2'd0, 4'b0000, 16'hFFFF, 4'b0000);
        add_row(1'b0, 4'b0000, 16'hFFFF, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        // Grant requester 1, then hold 1010: grants 3, 1, 3 back-to-back.
        add_row(1'b0, 4'b0010, 16'h00A0, 4'b0010, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        add_word(4'hA, 2'd1, 4'b1010, 16'h6050, 4'b1000);
        add_word(4'h6, 2'd3, 4'b1010, 16'h6050, 4'b0010);
        add_word(4'h5, 2'd1, 4'b1010, 16'h6050, 4'b1000);
        add_word(4'h6, 2'd3, 4'b0000, 16'h6050, 4'b0000);
        add_row(1'b0, 4'b0000, 16'h6050, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0);
        // Withdrawal: req_valid[2] pulses mid-word, outside the window.
        add_row(1'b0, 4'b0001, 16'h000C, 4'b0001, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0);
        add_row(1'b0, 4'b0000, 16'h000C, 4'b0000, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1);
        add_row(1'b0, 4'b0100, 16'h000C, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1);
        add_row(1'b0, 4'b0000, 16'h000C, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1);
        add_row(1'b0, 4'b0000, 16'h000C, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1);
        add_row(1'b0, 4'b0000, 16'h000C, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        // Pointer still at 0, so 1111 grants requester 1; reset lands on its 2nd bit.
        add_row(1'b0, 4'b1111, 16'h00C0, 4'b0010, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        add_row(1'b0, 4'b0000, 16'h00C0, 4'b0000, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1);
        add_row(1'b1, 4'b0000, 16'h00C0, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1);
        add_row(1'b0, 4'b0000, 16'h00C0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        add_row(1'b0, 4'b0000, 16'h00C0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        // After reset requester 0 first; saturation rotates 0,1,2,3,0.
        add_row(1'b0, 4'b1111, 16'h3C69, 4'b0001, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        add_word(4'h9, 2'd0, 4'b1111, 16'h3C69, 4'b0010);
        add_word(4'h6, 2'd1, 4'b1111, 16'h3C69, 4'b0100);
        add_word(4'hC, 2'd2, 4'b1111, 16'h3C69, 4'b1000);
        add_word(4'h3, 2'd3, 4'b1111, 16'h3C69, 4'b0001);
        add_word(4'h9, 2'd0, 4'b0000, 16'h3C69, 4'b0000);
        add_row(1'b0, 4'b0000, 16'h3C69, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);

        @(posedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1;
            rst           = tbl[i].rs;
            bus.req_valid = tbl[i].v;
            bus.req_data  = tbl[i].d;
            @(negedge clk);
            chk("req_ready",   i, 16'(bus.req_ready),   16'(tbl[i].rdy));
            chk("dout",        i, 16'(bus.dout),        16'(tbl[i].dout));
            chk("dout_valid",  i, 16'(bus.dout_valid),  16'(tbl[i].dv));
            chk("frame_start", i, 16'(bus.frame_start), 16'(tbl[i].fs));
            chk("src_id",      i, 16'(bus.src_id),      16'(tbl[i].src));
            chk("busy",        i, 16'(bus.busy),        16'(tbl[i].busy));
        end

        // Long saturation run: dout_valid must never drop, grants rotate every 4 cycles.
        @(posedge clk);
        #1;
        rst           = 1'b1;
        bus.req_valid = 4'b0000;
        @(posedge clk);
        #1;
        rst           = 1'b0;
        bus.req_valid = 4'b1111;
        bus.req_data  = 16'h3C69;
        for (int c = 0; c < 36; c++) begin
            @(negedge clk);
            if (c == 0) begin
                chk("sat_first_grant", c, 16'(bus.req_ready), 16'h0001);
            end else begin
                chk("sat_dout_valid", c, 16'(bus.dout_valid), 16'h0001);
                chk("sat_src_id", c, 16'(bus.src_id), 16'(((c - 1) / 4) % 4));
                chk("sat_frame_start", c, 16'(bus.frame_start), 16'(((c - 1) % 4) == 0));
                if (((c - 1) % 4) == 3) begin
                    chk("sat_req_ready", c, 16'(bus.req_ready), 16'(1 << ((((c - 1) / 4) + 1) % 4)));
                end else begin
                    chk("sat_req_ready", c, 16'(bus.req_ready), 16'h0000);
                end
            end
        end

        // Drop all requests; the word in flight must finish and busy fall within a bound.
        @(posedge clk);
        #1;
        bus.req_valid = 4'b0000;
        k = 0;
        while (bus.busy !== 1'b0 && k < 8) begin
            @(negedge clk);
            k++;
        end
        chk("drain_busy", k, 16'(bus.busy), 16'h0000);
        chk("drain_dout_valid", k, 16'(bus.dout_valid), 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
